// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legal opcode limit, flag bit
// positions and requester ids for the shared-ALU arbiter.
package alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_NOR   = 4'b0101;
   localparam logic [3:0] ALU_SLL   = 4'b0110;
   localparam logic [3:0] ALU_SRL   = 4'b0111;
   localparam logic [3:0] ALU_SRA   = 4'b1000;
   localparam logic [3:0] ALU_SLT   = 4'b1001;
   localparam logic [3:0] ALU_SLTU  = 4'b1010;
   localparam logic [3:0] ALU_PASSA = 4'b1011;
   localparam logic [3:0] ALU_PASSB = 4'b1100;

   localparam logic [3:0] MAX_OP = 4'b1100;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;

   localparam logic REQ_EX   = 1'b0;
   localparam logic REQ_ADDR = 1'b1;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU. Opcodes above MAX_OP raise err and force y to
// zero, which makes the flags read Z=1, N=0.
module alu #(
   parameter int              W      = 32,
   parameter int              OPW    = 4,
   parameter logic [OPW-1:0]  MAX_OP = 4'b1100
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [OPW-1:0] op,
   output logic [W-1:0]   y,
   output logic [1:0]     flags,
   output logic           err
);
   import alu_pkg::*;

   localparam int SHW = $clog2(W);

   logic [SHW-1:0] shamt;
   assign shamt = b[SHW-1:0];

   always_comb begin
      y   = '0;
      err = 1'b0;
      if (op > MAX_OP) begin
         err = 1'b1;
      end else begin
         case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOR:   y = ~(a | b);
            ALU_SLL:   y = a << shamt;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = W'($signed(a) >>> shamt);
            ALU_SLT:   y = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {{(W-1){1'b0}}, a < b};
            ALU_PASSA: y = a;
            ALU_PASSB: y = b;
            default:   y = '0;
         endcase
      end
   end

   always_comb begin
      flags         = 2'b00;
      flags[FLAG_Z] = (y == '0);
      flags[FLAG_N] = y[W-1];
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the EX stage
// (requester 0) and the address/branch-compare unit (requester 1).
module alu_share_arbiter #(
   parameter int              W      = 32,
   parameter int              OPW    = 4,
   parameter logic [OPW-1:0]  MAX_OP = 4'b1100
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   input  logic [OPW-1:0] req1_op,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic           resp_id,
   output logic [W-1:0]   resp_y,
   output logic [1:0]     resp_flags,
   output logic           resp_err
);
   import alu_pkg::*;

   // Handshake: a request transfers on a clk edge where req_valid[i] &
   // req_ready[i]; a response transfers where resp_valid & resp_ready.
   // Requesters hold operands stable while valid && !ready.

   logic           last_grant;
   logic [1:0]     grant;
   logic           grant_id;
   logic           can_accept;
   logic           accept;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [OPW-1:0] alu_op;
   logic [W-1:0]   alu_y;
   logic [1:0]     alu_flags;
   logic           alu_err;

   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == REQ_ADDR) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign grant_id   = grant[1];
   // The output register frees up in the same cycle it is drained.
   assign can_accept = !resp_valid || resp_ready;
   assign req_ready  = grant & {2{can_accept & rst_n}};
   assign accept     = |req_ready;

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
      if (grant[0]) begin
         alu_a  = req0_a;
         alu_b  = req0_b;
         alu_op = req0_op;
      end else if (grant[1]) begin
         alu_a  = req1_a;
         alu_b  = req1_b;
         alu_op = req1_op;
      end
   end

   alu #(
      .W      (W),
      .OPW    (OPW),
      .MAX_OP (MAX_OP)
   ) u_alu (
      .a     (alu_a),
      .b     (alu_b),
      .op    (alu_op),
      .y     (alu_y),
      .flags (alu_flags),
      .err   (alu_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_y     <= '0;
         resp_flags <= 2'b00;
         resp_err   <= 1'b0;
         last_grant <= REQ_ADDR;
      end else if (accept) begin
         resp_valid <= 1'b1;
         resp_id    <= grant_id;
         resp_y     <= alu_y;
         resp_flags <= alu_flags;
         resp_err   <= alu_err;
         last_grant <= grant_id;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational `alu` instance between two requesters: port 0 is the EX stage and port 1 is the address/branch-compare unit. Each requester uses a valid/ready handshake. The block grants round-robin, drives the shared ALU, and captures y/flags into a one-entry output register. The response carries the requester ID and uses downstream backpressure.

Parameters:
- W, 32, operand/result width; must match `alu`.
- OPW, 4, opcode width.
- MAX_OP, 4'b1100, highest legal opcode; opcodes above it are illegal.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; a transfer occurs when valid&ready.
- req0_a, req0_b  in  W  operands, requester 0.
- req0_op  in  OPW  opcode, requester 0.
- req1_a, req1_b  in  W  operands, requester 1.
- req1_op  in  OPW  opcode, requester 1.
- resp_valid  out  1  output register holds a result.
- resp_ready  in  1  downstream accepts the response.
- resp_id  out  1  requester the result belongs to.
- resp_y  out  W  ALU result.
- resp_flags  out  2  [0]=Z, [1]=N, as produced by `alu`.
- resp_err  out  1  illegal opcode; resp_y=0, resp_flags=2'b01.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - resp_valid=0, resp_id=0, resp_y=0, resp_flags=0, resp_err=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req_ready=0 throughout the reset cycle.
- Reset mid-operation: an unaccepted or held response is discarded. No response is produced for any request accepted before reset.
- State is implicit in resp_valid:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- can_accept = !resp_valid | resp_ready. This is a pass-through pipeline with throughput 1 op/cycle.
- Grant (combinational):
  - Only one requester valid: it is granted.
  - Both valid: the requester != last_grant is granted.
  - req_ready[i] = grant[i] & can_accept & rst_n.
  - At most one req_ready bit is high at any time.
- ALU mux: the shared `alu` inputs a/b/opcode come from the granted requester. With no grant they are zero.
- On accept (edge N):
  - resp_y, resp_flags, resp_err and resp_id are captured from the ALU and the grant.
  - resp_valid=1 at N+1. Latency is exactly 1 cycle.
  - last_grant := granted id.
- FULL & !resp_ready: all resp_* hold stable and req_ready=0 (stall). last_grant is unchanged.
- FULL & resp_ready & no new accept: resp_valid -> 0 next cycle.
- FULL & resp_ready & new accept in the same cycle: the register reloads and resp_valid stays 1 (no bubble).
- Illegal opcode (op > MAX_OP):
  - The request is accepted normally.
  - resp_err=1, resp_y=0, resp_flags=2'b01 (Z=1, N=0).
  - Illegal requests count as grants for the round-robin.
- Requester obligations: keep operands stable while valid && !ready. The arbiter does not check this.
- Fairness: with both valid continuously and resp_ready=1, grants alternate 0,1,0,1…
- Neither requester waits more than 1 grant while the other is served, excluding downstream stalls.
- Widths: operands pass unmodified. No extension or truncation happens in this block.

Decomposition:
- Shared package `alu_pkg`:
  - opcode constants ALU_ADD=4'b0000, ALU_SUB=4'b0001 … up to 4'b1100.
  - MAX_OP.
  - flag index constants FLAG_Z=0, FLAG_N=1.
  - requester id constants REQ_EX=0, REQ_ADDR=1.
- One sub-module: the existing `alu`, instantiated once and unchanged. The round-robin grant logic stays inline.

Test Plan:
1. Reset held 2 cycles with req_valid=2'b11 -> req_ready=0 and resp_valid=0 during reset. After release, the first grant is requester 0 and resp_id=0.
2. Requester 0 only: ALU_ADD, a=2, b=3, resp_ready=1 -> resp_valid at accept+1, resp_y=5, resp_flags=2'b00, resp_err=0. Next: ALU_SUB, a=7, b=7 -> resp_y=0, flags[0]=1.
3. Both valid continuously for 6 cycles, resp_ready=1 -> resp_id sequence 0,1,0,1,0,1 with no idle cycle between responses.
4. Backpressure: resp_ready=0 for 3 cycles while FULL -> resp_* stable, req_ready=2'b00. Raising resp_ready with a pending request -> drain and reload in the same cycle, resp_valid stays 1.
5. Requester 1 sends op=4'b1111 -> resp_err=1, resp_y=0, resp_flags=2'b01, resp_id=1. The next contention grants requester 0.
6. rst_n=0 while FULL with both requests pending -> resp_valid=0 the next cycle, and the held result is never presented.
